// File: rtl/onchip_mem_stream_loader_pkg.sv
`default_nettype none
// ============================================================================
// onchip_loader_pkg : shared types and helpers for the on-chip RAM loader
// Rev 1.0 - initial release
// ============================================================================
package onchip_loader_pkg;

    localparam int unsigned c_addr_w_default = 14;
    localparam int unsigned c_depth_default  = 10120;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PACK  = 3'd1,
        S_WRITE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Byte lanes covered by the first `count` bytes of a little-endian word
    function automatic logic [3:0] be_from_count(input logic [2:0] count);
        case (count)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_mem_stream_loader_packer.sv
`default_nettype none
// ============================================================================
// byte_word_packer : little-endian byte-to-word packer with lane tracking
// Rev 1.0 - initial release
// ============================================================================
module byte_word_packer
    import onchip_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  in_byte,
    output logic [1:0]  lane,
    output logic [31:0] data_next,
    output logic [3:0]  be_next
);

    logic [1:0]  r_lane;
    logic [31:0] r_data;

    // data_next/be_next describe the word as it would be with in_byte included
    always_comb begin
        data_next                      = r_data;
        data_next[{r_lane, 3'b000} +: 8] = in_byte;
        be_next                        = be_from_count({1'b0, r_lane} + 3'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lane <= 2'd0;
            r_data <= 32'd0;
        end else if (clear) begin
            r_lane <= 2'd0;
            r_data <= 32'd0;
        end else if (push) begin
            r_lane <= r_lane + 2'd1;
            r_data <= data_next;
        end
    end

    assign lane = r_lane;

endmodule
`default_nettype wire

// File: rtl/onchip_mem_stream_loader.sv
`default_nettype none
// ============================================================================
// onchip_mem_stream_loader : packs a byte stream into words and writes them
// to consecutive on-chip RAM addresses from a programmed base.
// Rev 1.0 - initial release
// ============================================================================
module onchip_mem_stream_loader
    import onchip_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = c_addr_w_default,
    parameter int unsigned DEPTH  = c_depth_default
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] max_words,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W-1:0] words_written
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_max;
    logic [ADDR_W-1:0] r_words;
    logic [ADDR_W-1:0] r_mem_address;
    logic [31:0]       r_mem_writedata;
    logic [3:0]        r_mem_byteenable;
    logic              r_err;
    logic              r_last;

    logic [1:0]        w_lane;
    logic [31:0]       w_data_next;
    logic [3:0]        w_be_next;
    logic [ADDR_W:0]   w_sum;
    logic              w_start;
    logic              w_accept;
    logic              w_ovf;
    logic              w_push;
    logic              w_clear;

    assign w_start  = (r_state == S_IDLE) && start;
    assign w_accept = (r_state == S_PACK) && in_valid;
    // One extra bit so base + count near the top of the address space cannot wrap
    assign w_sum    = {1'b0, r_base} + {1'b0, r_words};
    assign w_ovf    = (w_lane == 2'd0) &&
                      ((r_words == r_max) || (w_sum >= (ADDR_W+1)'(DEPTH)));
    assign w_push   = w_accept && !w_ovf;
    assign w_clear  = w_start || (r_state == S_WRITE);

    byte_word_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (w_clear),
        .push      (w_push),
        .in_byte   (in_data),
        .lane      (w_lane),
        .data_next (w_data_next),
        .be_next   (w_be_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_PACK;
            S_PACK: begin
                if (in_valid) begin
                    if (w_ovf)                         w_next = in_last ? S_DONE : S_DRAIN;
                    else if (w_lane == 2'd3 || in_last) w_next = S_WRITE;
                end
            end
            S_WRITE: w_next = r_last ? S_DONE : S_PACK;
            S_DRAIN: if (in_valid && in_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready       = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        case (r_state)
            S_IDLE:          busy = 1'b0;
            S_PACK, S_DRAIN: in_ready = 1'b1;
            S_WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
            end
            S_DONE:          done = 1'b1;
            default:         ;
        endcase
    end

    // Write address/data/lanes are loaded as the last byte of a word is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base           <= '0;
            r_max            <= '0;
            r_words          <= '0;
            r_err            <= 1'b0;
            r_last           <= 1'b0;
            r_mem_address    <= '0;
            r_mem_writedata  <= 32'd0;
            r_mem_byteenable <= 4'd0;
        end else begin
            if (w_start) begin
                r_base  <= base_addr;
                r_max   <= max_words;
                r_words <= '0;
                r_err   <= 1'b0;
            end
            if (w_accept && w_ovf)
                r_err <= 1'b1;
            if (w_push && (w_next == S_WRITE)) begin
                r_mem_address    <= r_base + r_words;
                r_mem_writedata  <= w_data_next;
                r_mem_byteenable <= w_be_next;
                r_last           <= in_last;
            end
            if (r_state == S_WRITE)
                r_words <= r_words + 1'b1;
        end
    end

    assign mem_address    = r_mem_address;
    assign mem_writedata  = r_mem_writedata;
    assign mem_byteenable = r_mem_byteenable;
    assign mem_clken      = 1'b1;
    assign err_overflow   = r_err;
    assign words_written  = r_words;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_stream_loader.sv
`default_nettype none
// ============================================================================
// tb_onchip_mem_stream_loader : directed self-checking bench for the loader
// Rev 1.0 - initial release
// ============================================================================
module tb_onchip_mem_stream_loader;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DEPTH  = 10120;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] max_words;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic              busy;
    logic              done;
    logic              err_overflow;
    logic [ADDR_W-1:0] words_written;

    int n_checks;
    int n_errors;
    int done_cnt;
    int conflict_cnt;
    int oor_cnt;
    logic [ADDR_W-1:0] q_addr[$];
    logic [31:0]       q_data[$];
    logic [3:0]        q_be[$];

    onchip_mem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .max_words      (max_words),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .done           (done),
        .err_overflow   (err_overflow),
        .words_written  (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM-side observer
    always @(negedge clk) begin
        if (mem_write) begin
            q_addr.push_back(mem_address);
            q_data.push_back(mem_writedata);
            q_be.push_back(mem_byteenable);
            if (in_ready)                conflict_cnt++;
            if (32'(mem_address) >= DEPTH) oor_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_be.delete();
        done_cnt     = 0;
        conflict_cnt = 0;
        oor_cnt      = 0;
    endtask

    task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] m);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        max_words = m;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int k;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 50) check_val("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] first, input logic [7:0] step, input int n, input bit gap);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            send_byte(b, (i == n - 1));
            b = b + step;
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 100) check_val({tag, "_done_timeout"}, 32'd0, 32'd1);
        else          check_val({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_val({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                               input logic [31:0] d, input logic [3:0] be);
        if (q_addr.size() > idx) begin
            check_val({tag, "_addr"}, 32'(q_addr[idx]), 32'(a));
            check_val({tag, "_data"}, q_data[idx], d);
            check_val({tag, "_be"},   32'(q_be[idx]), 32'(be));
        end else begin
            check_val({tag, "_missing"}, 32'(q_addr.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_val({tag, "_cs_we"},    {30'd0, mem_chipselect, mem_write}, 32'd0);
        check_val({tag, "_busy"},     {31'd0, busy}, 32'd0);
        check_val({tag, "_done"},     {31'd0, done}, 32'd0);
        check_val({tag, "_err"},      {31'd0, err_overflow}, 32'd0);
        check_val({tag, "_addr"},     32'(mem_address), 32'd0);
        check_val({tag, "_be"},       32'(mem_byteenable), 32'd0);
        check_val({tag, "_wdata"},    mem_writedata, 32'd0);
        check_val({tag, "_words"},    32'(words_written), 32'd0);
        check_val({tag, "_clken"},    {31'd0, mem_clken}, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        max_words = '0;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        clear_log();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        #1 reset_n = 1'b1;

        // two full words
        clear_log();
        start_load(14'h0010, 14'd4);
        check_val("s1_busy", {31'd0, busy}, 32'd1);
        send_seq(8'h01, 8'h01, 8, 1'b0);
        wait_done("s1");
        check_val("s1_nwrites", 32'(q_addr.size()), 32'd2);
        check_write("s1_w0", 0, 14'h0010, 32'h04030201, 4'b1111);
        check_write("s1_w1", 1, 14'h0011, 32'h08070605, 4'b1111);
        check_val("s1_words", 32'(words_written), 32'd2);
        check_val("s1_err", {31'd0, err_overflow}, 32'd0);
        check_val("s1_idle", {31'd0, busy}, 32'd0);

        // partial final word
        clear_log();
        start_load(14'h0020, 14'd4);
        send_seq(8'hAA, 8'h11, 3, 1'b0);
        wait_done("s2");
        check_val("s2_nwrites", 32'(q_addr.size()), 32'd1);
        check_write("s2_w0", 0, 14'h0020, 32'h00CCBBAA, 4'b0111);
        check_val("s2_words", 32'(words_written), 32'd1);

        // word limit reached, remainder drained
        clear_log();
        start_load(14'h0030, 14'd1);
        send_seq(8'h01, 8'h01, 6, 1'b0);
        wait_done("s3");
        check_val("s3_nwrites", 32'(q_addr.size()), 32'd1);
        check_write("s3_w0", 0, 14'h0030, 32'h04030201, 4'b1111);
        check_val("s3_err", {31'd0, err_overflow}, 32'd1);
        check_val("s3_words", 32'(words_written), 32'd1);

        // end of RAM reached before the word limit
        clear_log();
        start_load(14'd10118, 14'd8);
        send_seq(8'h10, 8'h01, 12, 1'b0);
        wait_done("s4");
        check_val("s4_nwrites", 32'(q_addr.size()), 32'd2);
        check_write("s4_w0", 0, 14'd10118, 32'h13121110, 4'b1111);
        check_write("s4_w1", 1, 14'd10119, 32'h17161514, 4'b1111);
        check_val("s4_err", {31'd0, err_overflow}, 32'd1);
        check_val("s4_oor", 32'(oor_cnt), 32'd0);
        check_val("s4_words", 32'(words_written), 32'd2);

        // throttled source
        clear_log();
        start_load(14'h0010, 14'd4);
        send_seq(8'h01, 8'h01, 8, 1'b1);
        wait_done("s5");
        check_val("s5_nwrites", 32'(q_addr.size()), 32'd2);
        check_write("s5_w0", 0, 14'h0010, 32'h04030201, 4'b1111);
        check_write("s5_w1", 1, 14'h0011, 32'h08070605, 4'b1111);
        check_val("s5_conflict", 32'(conflict_cnt), 32'd0);
        check_val("s5_err", {31'd0, err_overflow}, 32'd0);

        // zero word limit: first byte overflows
        clear_log();
        start_load(14'h0060, 14'd0);
        send_byte(8'h55, 1'b1);
        wait_done("s7");
        check_val("s7_nwrites", 32'(q_addr.size()), 32'd0);
        check_val("s7_err", {31'd0, err_overflow}, 32'd1);

        // reset mid-load, then reload from a new base
        clear_log();
        start_load(14'h0040, 14'd4);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("s6_rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("s6_nowrite", 32'(q_addr.size()), 32'd0);
        clear_log();
        start_load(14'h0050, 14'd4);
        send_seq(8'hA0, 8'h01, 5, 1'b0);
        wait_done("s6");
        check_val("s6_nwrites", 32'(q_addr.size()), 32'd2);
        check_write("s6_w0", 0, 14'h0050, 32'hA3A2A1A0, 4'b1111);
        check_write("s6_w1", 1, 14'h0051, 32'h000000A4, 4'b0001);
        check_val("s6_words", 32'(words_written), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
